rec_serializer: RTL and testbench
=================================

# rec_serializer

Downstream consumer of the 52-bit packed record (fields `a`, `aa`, `aaa`) produced by the struct/enum stage. Accepts one record per valid/ready handshake, holds it in a capture register, and emits it as a sequence of tagged 16-bit beats on a second valid/ready interface. Beat type is an enum tag. An enum-typed FSM sequences the beats, and a wrap-around counter reports completed records. Sits between the record producer and the narrow link/packet framer.

## Interface
- `SKIP_ZERO_AUX`, default 0: when 1, the AUX beat is omitted for records with `aa == 0`.
- `CNT_WIDTH`, default 8: width of the completed-record counter.

Ports:
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_rst_n`  input  1  reset; asynchronous and active-low.
- `i_valid`  input  1  upstream record valid.
- `o_ready`  output  1  block can accept a record this cycle.
- `i_rec`  input  52  packed record: `a` is [51:42] (10b), `aa` is [41:32] (10b), `aaa` is [31:0] (32b unsigned).
- `o_valid`  output  1  beat valid.
- `i_ready`  input  1  downstream accepts the beat.
- `o_tag`  output  2  beat tag enum: `TAG_HDR`=2'd0, `TAG_AUX`=2'd1, `TAG_LO`=2'd2, `TAG_HI`=2'd3.
- `o_data`  output  16  beat payload.
- `o_last`  output  1  final beat of the record (always coincides with `TAG_HI`).
- `o_count`  output  CNT_WIDTH  count of records whose last beat has been accepted; wraps modulo 2^CNT_WIDTH.

## Operation
- FSM states (enum, 3-bit): `S_IDLE`, `S_HDR`, `S_AUX`, `S_LO`, `S_HI`.
- A record is accepted when `i_valid && o_ready`. The record is then latched into the capture register `rec_q`.
- `o_ready` = (state == `S_IDLE`) || (state == `S_HI` && `i_ready`). This gives back-to-back operation with no bubble.
- Transitions:
  - `S_IDLE` goes to `S_HDR` on accept.
  - `S_HDR` advances on beat accept. It goes to `S_LO` if `SKIP_ZERO_AUX && rec_q.aa == 0`; otherwise it goes to `S_AUX`.
  - `S_AUX` goes to `S_LO` on beat accept.
  - `S_LO` goes to `S_HI` on beat accept.
  - `S_HI` advances on beat accept. It goes to `S_HDR` if a new record is accepted in the same cycle; otherwise it goes to `S_IDLE`.
- While not accepted (`o_valid && !i_ready`), the state holds and `o_tag`, `o_data` and `o_last` stay stable.
- Beat payloads:
  - HDR: {6'b0, `a`}.
  - AUX: {6'b0, `aa`}.
  - LO: `aaa[15:0]`.
  - HI: `aaa[31:16]`.
- `o_valid` = (state != `S_IDLE`).
- `o_tag`, `o_data` and `o_last` are decoded from state and `rec_q` only; there is no combinational path from `i_rec`.
- In `S_IDLE`, `o_tag`=`TAG_HDR` and `o_data`=0.
- `o_count` increments by 1 on each accepted HI beat. It wraps from 2^CNT_WIDTH−1 to 0.
- Reset (asynchronous assert, at any time including mid-record):
  - state returns to `S_IDLE`; any partial record is dropped with no further beats.
  - `rec_q`=0 and `o_count`=0.
  - outputs: `o_ready`=1, `o_valid`=0, `o_tag`=`TAG_HDR`, `o_data`=0, `o_last`=0.

## Timing
- Latency: a record accepted at edge N presents its HDR beat from cycle N+1.
- Throughput: 4 beats per record, or 3 with the AUX skip, under continuous `i_ready`. A new record can be accepted in the HI cycle, so the next HDR follows immediately.
- `o_ready` depends combinationally on `i_ready`, and only in `S_HI`.
- Upstream must hold `i_rec` stable only until acceptance.

## Structure
- Shared package `rec_pkg` holds:
  - the `rec_t` packed struct (`a`, `aa`, `aaa`);
  - the `tag_t` enum (2-bit, explicit values);
  - the `state_t` enum;
  - the `REC_WIDTH`=52 and `BEAT_WIDTH`=16 constants.
- Single module. The beat-payload mux is an always_comb block inside it; no sub-module is needed.

## Test plan
- Single record, `i_ready`=1: send a=10'h3FF, aa=10'h001, aaa=32'hDEAD_BEEF. Expect 4 consecutive beats:
  - (HDR, 16'h03FF)
  - (AUX, 16'h0001)
  - (LO, 16'hBEEF)
  - (HI, 16'hDEAD, last=1)
  - then `o_count`=1.
- Back-to-back: present 3 records with `i_valid` held high. Expect 12 beats with no idle cycle, `o_ready` high only in IDLE and in HI cycles, and `o_count`=3.
- Backpressure: drop `i_ready` for 3 cycles during the LO beat. The LO tag and data must stay stable, `o_ready`=0 throughout, and the HI beat follows after release.
- `SKIP_ZERO_AUX`=1 with aa=0, aaa=32'h0000_0001: expect beats HDR, LO (16'h0001), HI (16'h0000, last). With aa=1, all 4 beats are sent.
- Counter wrap (CNT_WIDTH=2): send 5 records. Expect `o_count` to step 1, 2, 3, 0, 1.
- Reset mid-record: assert `i_rst_n`=0 during the AUX beat. Outputs return to their reset values immediately, without waiting for a clock edge. After release, the next record starts at HDR and `o_count`=0.

Source files
------------

// File: rtl/rec_pkg.sv
// Shared types for the record serializer: packed record layout, beat tags, FSM states.
package rec_pkg;

  localparam int REC_WIDTH  = 52;
  localparam int BEAT_WIDTH = 16;

  typedef struct packed {
    logic [9:0]  a;
    logic [9:0]  aa;
    logic [31:0] aaa;
  } rec_t;

  typedef enum logic [1:0] {
    TAG_HDR = 2'd0,
    TAG_AUX = 2'd1,
    TAG_LO  = 2'd2,
    TAG_HI  = 2'd3
  } tag_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_AUX,
    S_LO,
    S_HI
  } state_t;

endpackage

// File: rtl/rec_serializer.sv
// Captures one 52-bit record per handshake and streams it out as tagged 16-bit beats
// (HDR, optional AUX, LO, HI), counting records whose final beat was accepted.
module rec_serializer
  import rec_pkg::*;
#(
  parameter bit SKIP_ZERO_AUX = 1'b0,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [REC_WIDTH-1:0]  i_rec,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [1:0]            o_tag,
  output logic [BEAT_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [CNT_WIDTH-1:0]  o_count
);

  state_t state;
  rec_t   rec_q;
  tag_t   tag;
  logic   rec_acc;
  logic   beat_acc;

  // Accepting in S_HI only when the HI beat leaves keeps back-to-back records bubble-free.
  assign o_ready  = (state == S_IDLE) || ((state == S_HI) && i_ready);
  assign o_valid  = (state != S_IDLE);
  assign rec_acc  = i_valid && o_ready;
  assign beat_acc = o_valid && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      rec_q   <= '0;
      o_count <= '0;
    end else begin
      if (rec_acc) rec_q <= i_rec;
      case (state)
        S_IDLE: if (rec_acc) state <= S_HDR;
        S_HDR:
          if (beat_acc) state <= (SKIP_ZERO_AUX && (rec_q.aa == '0)) ? S_LO : S_AUX;
        S_AUX:  if (beat_acc) state <= S_LO;
        S_LO:   if (beat_acc) state <= S_HI;
        S_HI:
          if (beat_acc) begin
            state   <= rec_acc ? S_HDR : S_IDLE;
            o_count <= o_count + CNT_WIDTH'(1);
          end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Beat fields come only from state and rec_q, so they stay put under backpressure.
  always_comb begin
    tag    = TAG_HDR;
    o_data = '0;
    o_last = 1'b0;
    case (state)
      S_HDR: begin
        tag    = TAG_HDR;
        o_data = {6'b0, rec_q.a};
      end
      S_AUX: begin
        tag    = TAG_AUX;
        o_data = {6'b0, rec_q.aa};
      end
      S_LO: begin
        tag    = TAG_LO;
        o_data = rec_q.aaa[15:0];
      end
      S_HI: begin
        tag    = TAG_HI;
        o_data = rec_q.aaa[31:16];
        o_last = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_tag = tag;

endmodule

// File: tb/tb_rec_serializer.sv
// Bench for rec_serializer: two instances (default, and AUX-skip with a 2-bit counter),
// a queue-based beat scoreboard per instance, a vector table and hand corner sequences.
module tb_rec_serializer;

  localparam int N = 2;

  typedef struct packed {
    logic [1:0]  tag;
    logic [15:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    int          g;
    logic [51:0] rec;
    int          nb;
    logic [17:0] bt [4];
  } vec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        vin, rdy_in, rdy_out, vout, last;
  logic [N-1:0][51:0]  rec;
  logic [N-1:0][1:0]   tag;
  logic [N-1:0][15:0]  data;
  logic [N-1:0][7:0]   cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam bit SK = (g == 1);
    localparam int CW = (g == 1) ? 2 : 8;
    logic [CW-1:0] cnt_w;

    rec_serializer #(.SKIP_ZERO_AUX(SK), .CNT_WIDTH(CW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_valid (vin[g]),
      .o_ready (rdy_out[g]),
      .i_rec   (rec[g]),
      .o_valid (vout[g]),
      .i_ready (rdy_in[g]),
      .o_tag   (tag[g]),
      .o_data  (data[g]),
      .o_last  (last[g]),
      .o_count (cnt_w)
    );
    assign cnt[g] = 8'(cnt_w);

    // Reference: each accepted record expands into its list of pending beats.
    beat_t q[$];
    int    mcnt = 0;

    always @(negedge clk) begin : sb
      beat_t       b;
      logic        er;
      logic [51:0] r;
      if (!rst_n) begin
        q.delete();
        mcnt = 0;
        chk("rst_valid", vout[g], 0);
        chk("rst_ready", rdy_out[g], 1);
        chk("rst_tag", tag[g], 0);
        chk("rst_data", data[g], 0);
        chk("rst_last", last[g], 0);
        chk("rst_count", cnt[g], 0);
      end else begin
        er = (q.size() == 0) || ((q.size() == 1) && rdy_in[g]);
        b  = (q.size() == 0) ? beat_t'(0) : q[0];
        chk("sb_ready", rdy_out[g], er);
        chk("sb_valid", vout[g], q.size() != 0);
        chk("sb_tag", tag[g], b.tag);
        chk("sb_data", data[g], b.data);
        chk("sb_last", last[g], b.last);
        chk("sb_count", cnt[g], mcnt % (1 << CW));
        if (q.size() != 0 && rdy_in[g]) begin
          if (q[0].last) mcnt++;
          void'(q.pop_front());
        end
        if (vin[g] && er) begin
          r = rec[g];
          q.push_back({2'd0, 6'd0, r[51:42], 1'b0});
          if (!(SK && r[41:32] == 10'd0)) q.push_back({2'd1, 6'd0, r[41:32], 1'b0});
          q.push_back({2'd2, r[15:0], 1'b0});
          q.push_back({2'd3, r[31:16], 1'b1});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [51:0] rnd_rec();
    logic [51:0] r;
    r = 52'({$urandom(), $urandom()});
    if ($urandom_range(0, 2) == 0) r[41:32] = 10'd0;
    return r;
  endfunction

  vec_t tbl [4];
  int   exp_w [5];
  logic done;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vin = '0; rdy_in = '0; rec = '0;
    tbl[0] = '{0, {10'h3FF, 10'h001, 32'hDEAD_BEEF}, 4,
               '{{2'd0, 16'h03FF}, {2'd1, 16'h0001}, {2'd2, 16'hBEEF}, {2'd3, 16'hDEAD}}};
    tbl[1] = '{1, {10'h2A5, 10'h000, 32'h0000_0001}, 3,
               '{{2'd0, 16'h02A5}, {2'd2, 16'h0001}, {2'd3, 16'h0000}, 18'd0}};
    tbl[2] = '{1, {10'h000, 10'h001, 32'h1234_5678}, 4,
               '{{2'd0, 16'h0000}, {2'd1, 16'h0001}, {2'd2, 16'h5678}, {2'd3, 16'h1234}}};
    tbl[3] = '{0, {10'h001, 10'h000, 32'hFFFF_0000}, 4,
               '{{2'd0, 16'h0001}, {2'd1, 16'h0000}, {2'd2, 16'h0000}, {2'd3, 16'hFFFF}}};
    exp_w = '{1, 2, 3, 0, 1};

    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single records, ready held high: exact beat sequence starting the cycle after accept.
    for (int e = 0; e < 4; e++) begin
      vin[tbl[e].g] = 1'b1; rec[tbl[e].g] = tbl[e].rec; rdy_in[tbl[e].g] = 1'b1;
      tick();
      vin[tbl[e].g] = 1'b0;
      for (int k = 0; k < tbl[e].nb; k++) begin
        @(negedge clk);
        chk("tbl_valid", vout[tbl[e].g], 1);
        chk("tbl_tag", tag[tbl[e].g], tbl[e].bt[k][17:16]);
        chk("tbl_data", data[tbl[e].g], tbl[e].bt[k][15:0]);
        chk("tbl_last", last[tbl[e].g], k == tbl[e].nb - 1);
        tick();
      end
      @(negedge clk);
      chk("tbl_idle", vout[tbl[e].g], 0);
      tick();
      rdy_in[tbl[e].g] = 1'b0;
    end

    // Back-to-back: three records, valid held high, no idle beat in between.
    do_reset();
    rdy_in[0] = 1'b1; vin[0] = 1'b1; rec[0] = {10'h011, 10'h022, 32'h3333_4444};
    tick();
    rec[0] = {10'h055, 10'h000, 32'h7777_8888};
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("b2b_valid", vout[0], 1);
      chk("b2b_ready", rdy_out[0], (k % 4) == 3);
      chk("b2b_tag", tag[0], k % 4);
      tick();
      if (k == 3) rec[0] = {10'h099, 10'h0AA, 32'hBBBB_CCCC};
      if (k == 7) vin[0] = 1'b0;
    end
    @(negedge clk);
    chk("b2b_idle", vout[0], 0);
    chk("b2b_count", cnt[0], 3);
    tick();
    rdy_in[0] = 1'b0;

    // Backpressure on the LO beat for three edges.
    do_reset();
    rdy_in[0] = 1'b1; vin[0] = 1'b1; rec[0] = {10'h123, 10'h045, 32'hCAFE_F00D};
    tick();
    vin[0] = 1'b0;
    @(negedge clk); chk("bp_hdr", tag[0], 0); tick();
    @(negedge clk); chk("bp_aux", tag[0], 1); tick();
    rdy_in[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_lo_tag", tag[0], 2);
      chk("bp_lo_data", data[0], 16'hF00D);
      chk("bp_lo_ready", rdy_out[0], 0);
      if (i == 3) rdy_in[0] = 1'b1;
      tick();
    end
    @(negedge clk);
    chk("bp_hi_tag", tag[0], 3);
    chk("bp_hi_data", data[0], 16'hCAFE);
    chk("bp_hi_last", last[0], 1);
    tick();
    @(negedge clk);
    chk("bp_count", cnt[0], 1);
    tick();

    // Reset asserted mid-record (AUX beat): outputs clear before any clock edge.
    vin[0] = 1'b1; rec[0] = {10'h3C3, 10'h1E1, 32'h0F0F_A5A5};
    tick();
    vin[0] = 1'b0;
    @(negedge clk); chk("mr_hdr", tag[0], 0); tick();
    @(negedge clk); chk("mr_aux", tag[0], 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_valid", vout[0], 0);
    chk("mr_ready", rdy_out[0], 1);
    chk("mr_tag", tag[0], 0);
    chk("mr_data", data[0], 0);
    chk("mr_last", last[0], 0);
    chk("mr_count", cnt[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mr_post_count", cnt[0], 0);
    chk("mr_post_valid", vout[0], 0);
    tick();
    vin[0] = 1'b1; rec[0] = {10'h2BC, 10'h001, 32'h1111_2222};
    tick();
    vin[0] = 1'b0;
    @(negedge clk);
    chk("mr_new_tag", tag[0], 0);
    chk("mr_new_data", data[0], 16'h02BC);
    repeat (5) tick();
    rdy_in[0] = 1'b0;

    // Counter wrap on the 2-bit instance.
    do_reset();
    rdy_in[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vin[1] = 1'b1; rec[1] = rnd_rec();
      tick();
      vin[1] = 1'b0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
        @(negedge clk);
        done = vout[1] && last[1];
        tick();
      end
      chk("wrap_done", done, 1);
      @(negedge clk);
      chk("wrap_count", cnt[1], exp_w[i]);
      tick();
    end
    rdy_in[1] = 1'b0;

    // Random traffic on both instances; the scoreboards do the checking.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int g = 0; g < N; g++) begin
        vin[g]    = 1'($urandom_range(0, 1));
        rdy_in[g] = ($urandom_range(0, 3) != 0);
        rec[g]    = rnd_rec();
      end
      if (cyc == 1500) rst_n = 1'b0;
      if (cyc == 1502) rst_n = 1'b1;
      tick();
    end
    vin = '0;
    rdy_in = '1;
    repeat (8) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
